ins_fetch_unit: RTL and testbench
=================================

// Module: ins_fetch_unit
// PURPOSE
//  Parametrised fetch stage for the 6-stage MIPS pipeline. Generates sequential PCs, issues
//  in-order requests to instruction memory and buffers returned words in a prefetch FIFO.
//  Presents inscode/PC to decode over a valid/ready handshake; supports stall and branch redirect.
// PARAMETERS
//  PC_W      32           PC / address width (bits)
//  INS_W     32           instruction word width
//  RESET_PC  32'h0        PC value loaded on reset
//  DEPTH     4            prefetch FIFO entries = max in-flight + buffered words (power of 2, >=2)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  imem_req     out  1      request valid to instruction memory
//  imem_addr    out  PC_W   request address (word aligned)
//  imem_gnt     in   1      request accepted this cycle (req&gnt = issue)
//  imem_rvalid  in   1      response valid, returned in issue order
//  imem_rdata   in   INS_W  response instruction word
//  redirect     in   1      branch/jump taken; flush and refetch from redirect_pc
//  redirect_pc  in   PC_W   new fetch target
//  if_valid     out  1      inscode/if_pc valid to decode
//  if_ready     in   1      decode accepts (valid&ready = handshake); low = stall
//  inscode      out  INS_W  fetched instruction
//  if_pc        out  PC_W   address of inscode
//  fetch_cnt    out  32     [IF_PERF_CNT_EN only] instructions delivered to decode
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, in-flight=0, kill=0; imem_req=0, if_valid=0,
//   inscode=0, if_pc=0, fetch_cnt=0. Reset mid-transaction drops all in-flight words.
//  Issue: imem_req=1 when (fifo_count+inflight)<DEPTH; imem_addr=fetch_pc. On req&gnt:
//   fetch_pc+=4 (wraps modulo 2^PC_W), inflight+=1. imem_addr held stable while req&!gnt.
//  Response: imem_rvalid with kill==0 pushes {rdata, pc_of_request} to FIFO, inflight-=1.
//   With kill>0 the word is discarded, kill-=1, inflight-=1. Credit check guarantees no
//   overflow; push into full FIFO is impossible and is a checked assertion.
//  Output: if_valid = FIFO non-empty; inscode/if_pc = FIFO head (combinational from head).
//   Pop on if_valid&if_ready. Simultaneous push+pop keeps count. Latency: response in
//   cycle N visible on if_valid in N+1 (registered FIFO write), min gnt->if_valid 2 cycles.
//  Redirect (highest priority, same edge): FIFO cleared; kill=inflight minus any response
//   arriving this cycle (that response also discarded); fetch_pc=redirect_pc; imem_req
//   forced 0 in the redirect cycle; next cycle issues redirect_pc. A handshake to decode
//   in the redirect cycle still completes (decode consumes it). redirect_pc[1:0] ignored (forced 0).
//  Stall: if_ready=0 holds head; fetch continues until credits exhausted, then imem_req=0.
//  Counters sized clog2(DEPTH)+1; inflight never exceeds DEPTH, kill never exceeds inflight.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: fetch_cnt port present; increments on each if_valid&if_ready,
//   wraps at 2^32, reset 0, not cleared by redirect.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pkg: PC_W/INS_W defaults, RESET_PC, PC_STEP=4, fetch entry struct/
//   width macro {pc, ins}. One sub-module: if_fifo (sync FIFO, DEPTH x (PC_W+INS_W),
//   push/pop/flush, count/empty/full). Credit, kill and PC logic stay in ins_fetch_unit.
// TESTING
//  1 rst high then release, gnt=1, rvalid 1 cycle after gnt, if_ready=1 -> if_pc 0,4,8,12...
//    consecutive, first if_valid 2 cycles after first issue.
//  2 if_ready=0 for 10 cycles -> exactly 4 requests issued (DEPTH=4), imem_req drops, head
//    if_pc holds 0; release -> 0,4,8,12,16 in order, no loss/duplication.
//  3 gnt held 0 for 3 cycles -> imem_addr stable at same value, fetch_pc not advanced.
//  4 redirect to 0x100 with 2 in flight -> next 2 rvalid words dropped, next if_pc=0x100,
//    then 0x104; FIFO contents before redirect never appear.
//  5 redirect coincident with rvalid and if_valid&if_ready -> head consumed, incoming word
//    dropped, kill=inflight-1; RESET_PC=0xFFFFFFFC -> next PC wraps to 0.
//  6 assert rst mid-stream -> all outputs 0 immediately (async); with IF_PERF_CNT_EN,
//    fetch_cnt equals handshake count (e.g. 20 after 20 pops) and resets to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: default widths, reset PC, PC step and the {pc, ins}
// fetch entry layout used by the prefetch FIFO.
package mips_pkg;
  localparam int          PC_W_DEF     = 32;
  localparam int          INS_W_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int          PC_STEP      = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] ins;
  } fetch_entry_t;
endpackage

`define IF_ENTRY_W(pcw, insw) ((pcw) + (insw))

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO, DEPTH x W bits, with push/pop/flush and count/empty/full.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
endmodule

// File: rtl/ins_fetch_unit.sv
// MIPS fetch stage: credit-limited in-order imem requests, prefetch FIFO, redirect with kill.
// Optional IF_PERF_CNT_EN adds the fetch_cnt delivered-instruction counter port.
module ins_fetch_unit
  import mips_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INS_W    = INS_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [INS_W-1:0] inscode,
  output logic [PC_W-1:0]  if_pc
`ifdef IF_PERF_CNT_EN
  , output logic [31:0]    fetch_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = `IF_ENTRY_W(PC_W, INS_W);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   kill_q, kill_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty, fifo_full;
  logic            issue, push, pop;
  logic [PC_W-1:0] target_pc;
  logic [EW-1:0]   push_data, head_data;

  always_comb begin
    credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    imem_addr   = fetch_pc_q;
    issue       = imem_req && imem_gnt;
    push        = imem_rvalid && (kill_q == '0) && !redirect;
    pop         = if_valid && if_ready;
    push_data   = {resp_pc_q, imem_rdata};
    target_pc   = redirect_pc & ~PC_W'(3);

    fetch_pc_d = issue ? fetch_pc_q + PC_W'(PC_STEP) : fetch_pc_q;
    resp_pc_d  = push ? resp_pc_q + PC_W'(PC_STEP) : resp_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
    kill_d     = (imem_rvalid && (kill_q != '0)) ? kill_q - CW'(1) : kill_q;
    // No issue can happen in the redirect cycle, so every remaining in-flight word is stale.
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      kill_d     = inflight_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  if_fifo #(.DEPTH(DEPTH), .W(EW), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign if_valid          = !fifo_empty;
  assign {if_pc, inscode}  = head_data;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb fetch_cnt_d = fetch_cnt_q + 32'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt_q <= '0;
    else     fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif
endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based fetch model.
module tb_ins_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, if_valid, if_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inscode, if_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_ins, w_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, w_fetch_cnt;
`endif

  always #5 clk = ~clk;

  ins_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .inscode(inscode), .if_pc(if_pc)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  ins_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(w_valid),
    .if_ready(if_ready), .inscode(w_ins), .if_pc(w_pc)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(w_fetch_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  typedef struct { logic [31:0] addr; bit killed; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  req_t        m_out[$];
  ent_t        m_fifo[$];
  logic [31:0] m_pc;
  int unsigned m_pops;

  bit          o_req, o_valid, did_issue, did_pop;
  logic [31:0] o_addr, o_pc;

  typedef struct {
    bit gnt; bit rv; bit rdy;
    bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[6];

  typedef struct { int gnt_pct; int rv_pct; int rdy_pct; int redir_pct; } cfg_t;
  cfg_t cfgs[3];

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_out.delete();
    m_fifo.delete();
    m_pops = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0; redirect = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit gnt, input bit rv, input bit rdy, input bit redir,
                      input logic [31:0] rpc);
    bit   exp_req, rv_eff;
    req_t r;
    @(negedge clk);
    rv_eff = rv && (m_out.size() > 0);
    imem_gnt = gnt;
    imem_rvalid = rv_eff;
    imem_rdata = 32'h0;
    if (rv_eff) imem_rdata = ins_of(m_out[0].addr);
    if_ready = rdy;
    redirect = redir;
    redirect_pc = rpc;
    #1;
    exp_req = !redir && ((m_fifo.size() + m_out.size()) < DEPTH);
    chk("imem_req", {63'b0, imem_req}, {63'b0, exp_req});
    if (exp_req) chk("imem_addr", {32'b0, imem_addr}, {32'b0, m_pc});
    chk("if_valid", {63'b0, if_valid}, {63'b0, m_fifo.size() != 0});
    if (m_fifo.size() != 0) begin
      chk("if_pc", {32'b0, if_pc}, {32'b0, m_fifo[0].pc});
      chk("inscode", {32'b0, inscode}, {32'b0, m_fifo[0].ins});
    end
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", {32'b0, fetch_cnt}, {32'b0, m_pops});
`endif
    o_req = imem_req; o_addr = imem_addr; o_valid = if_valid; o_pc = if_pc;
    did_issue = exp_req && gnt;
    did_pop = (m_fifo.size() != 0) && rdy;
    if (did_pop) begin
      void'(m_fifo.pop_front());
      m_pops++;
    end
    if (rv_eff) begin
      r = m_out.pop_front();
      if (!r.killed && !redir) m_fifo.push_back('{pc: r.addr, ins: ins_of(r.addr)});
    end
    if (did_issue) begin
      m_out.push_back('{addr: m_pc, killed: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].killed = 1'b1;
      m_pc = rpc & ~32'd3;
    end
  endtask

  initial begin
    int n;
    logic [31:0] got[8];
    logic [31:0] iss[2];
    int ni;

    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; if_ready = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    cfgs[0] = '{90, 80, 90, 2};
    cfgs[1] = '{50, 40, 30, 4};
    cfgs[2] = '{70, 90, 10, 3};

    #1 rst = 1'b1;
    model_reset();
    @(negedge clk); #1;
    chk("rst_req", {63'b0, imem_req}, 64'd0);
    chk("rst_valid", {63'b0, if_valid}, 64'd0);
    chk("rst_inscode", {32'b0, inscode}, 64'd0);
    chk("rst_if_pc", {32'b0, if_pc}, 64'd0);
    chk("rst_addr", {32'b0, imem_addr}, 64'd0);
    chk("rst_wrap_addr", {32'b0, w_addr}, 64'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
    chk("rst_fetch_cnt", {32'b0, fetch_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Streaming from reset: table of per-cycle inputs and expected outputs
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].gnt, tbl[i].rv, tbl[i].rdy, 1'b0, 32'h0);
      chk("tbl_req", {63'b0, o_req}, {63'b0, tbl[i].exp_req});
      chk("tbl_addr", {32'b0, o_addr}, {32'b0, tbl[i].exp_addr});
      chk("tbl_valid", {63'b0, o_valid}, {63'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk("tbl_pc", {32'b0, o_pc}, {32'b0, tbl[i].exp_pc});
      if (i == 0) chk("wrap_first_addr", {32'b0, w_addr}, 64'hFFFF_FFFC);
      if (i == 1) chk("wrap_next_addr", {32'b0, w_addr}, 64'd0);
    end

    // Stall: credits run out after DEPTH requests, head holds
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (did_issue) n++;
    end
    chk("stall_issues", n, DEPTH);
    chk("stall_req_low", {63'b0, o_req}, 64'd0);
    chk("stall_head_valid", {63'b0, o_valid}, 64'd1);
    chk("stall_head_pc", {32'b0, o_pc}, 64'd0);
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (did_pop) begin got[n] = o_pc; n++; end
    end
    chk("stall_release_count", n, 5);
    for (int k = 0; k < n; k++) chk("stall_release_pc", {32'b0, got[k]}, 64'(4 * k));

    // Grant held off: address stable, PC not advanced
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("nognt_req", {63'b0, o_req}, 64'd1);
      chk("nognt_addr", {32'b0, o_addr}, 64'd8);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("gnt_addr", {32'b0, o_addr}, 64'd8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("gnt_next_addr", {32'b0, o_addr}, 64'd12);

    // Redirect with two words in flight and one buffered
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0101);
    chk("redir_req_low", {63'b0, o_req}, 64'd0);
    n = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (did_pop) begin got[n] = o_pc; n++; end
    end
    chk("redir_count", n, 2);
    chk("redir_pc0", {32'b0, got[0]}, 64'h100);
    chk("redir_pc1", {32'b0, got[1]}, 64'h104);

    // Redirect coincident with a response and a decode handshake; target wraps
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("coinc_valid", {63'b0, o_valid}, 64'd1);
    chk("coinc_head_pc", {32'b0, o_pc}, 64'd0);
    chk("coinc_req_low", {63'b0, o_req}, 64'd0);
    n = 0; ni = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (did_issue && ni < 2) begin iss[ni] = o_addr; ni++; end
      if (did_pop) begin got[n] = o_pc; n++; end
    end
    chk("coinc_count", n, 2);
    chk("coinc_issue0", {32'b0, iss[0]}, 64'hFFFF_FFFC);
    chk("coinc_issue1", {32'b0, iss[1]}, 64'h0);
    chk("coinc_pc0", {32'b0, got[0]}, 64'hFFFF_FFFC);
    chk("coinc_pc1", {32'b0, got[1]}, 64'h0);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 700; c++) begin
        step($urandom_range(0, 99) < cfgs[k].gnt_pct, $urandom_range(0, 99) < cfgs[k].rv_pct,
             $urandom_range(0, 99) < cfgs[k].rdy_pct, $urandom_range(0, 99) < cfgs[k].redir_pct,
             $urandom());
      end
    end

    // Handshake count, then asynchronous reset mid-stream
    do_reset();
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (did_pop) n++;
    end
    chk("pop20_count", n, 20);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_20", {32'b0, fetch_cnt}, 64'd20);
`endif
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {63'b0, imem_req}, 64'd0);
    chk("arst_addr", {32'b0, imem_addr}, 64'd0);
    chk("arst_valid", {63'b0, if_valid}, 64'd0);
    chk("arst_inscode", {32'b0, inscode}, 64'd0);
    chk("arst_if_pc", {32'b0, if_pc}, 64'd0);
`ifdef IF_PERF_CNT_EN
    chk("arst_fetch_cnt", {32'b0, fetch_cnt}, 64'd0);
`endif
    imem_gnt = 0; imem_rvalid = 0; if_ready = 0; redirect = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++)
      step($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
